// File: rtl/pc_pkg.sv
// Package shared by the next-PC unit.
// Holds the redirect class codes (ordered so that a numerically larger code
// wins), the class width, default increment/vector constants, and the helper
// that turns the raw request strobes into a single live redirect class.
package pc_pkg;

  localparam int CLS_W = 2;

  typedef enum logic [CLS_W-1:0] {
    CLS_SEQ    = 2'd0,
    CLS_JUMP   = 2'd1,
    CLS_BRANCH = 2'd2,
    CLS_EXC    = 2'd3
  } redir_cls_e;

  localparam int          DEF_ADDR_W       = 32;
  localparam int unsigned DEF_INC          = 4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

  // Highest-priority live request; CLS_SEQ when nothing is requested.
  function automatic redir_cls_e live_class(input logic exc, input logic br,
                                            input logic jmp);
    redir_cls_e c;
    c = CLS_SEQ;
    if (exc)      c = CLS_EXC;
    else if (br)  c = CLS_BRANCH;
    else if (jmp) c = CLS_JUMP;
    return c;
  endfunction

endpackage

// File: rtl/mod_pc_next_unit_if.sv
// Fetch-side bus of the next-PC unit.
// Requests and stall flow from the pipeline (master) into the unit (slave);
// the fetch address, PC+INC, valid and pending flag flow back.
//   stall_in, exc_valid, branch_taken, branch_address, jump_valid,
//   jump_address          : master -> slave
//   pc_out, pc_plus_inc, pc_valid, redirect_pending : slave -> master
interface mod_pc_next_unit_if #(
  parameter int ADDR_W = 32
);

  logic              stall_in;
  logic              exc_valid;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_address;
  logic              jump_valid;
  logic [ADDR_W-1:0] jump_address;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W-1:0] pc_plus_inc;
  logic              pc_valid;
  logic              redirect_pending;

  modport master (
    output stall_in, exc_valid, branch_taken, branch_address,
           jump_valid, jump_address,
    input  pc_out, pc_plus_inc, pc_valid, redirect_pending
  );

  modport slave (
    input  stall_in, exc_valid, branch_taken, branch_address,
           jump_valid, jump_address,
    output pc_out, pc_plus_inc, pc_valid, redirect_pending
  );

endinterface

// File: rtl/mod_pc_redirect_hold.sv
// Pending-redirect buffer for the next-PC unit.
// While stalled it captures the live redirect when the buffer is empty or the
// live class is at least as high as the buffered one (equal class keeps the
// newest target). When not stalled it arbitrates buffered vs live redirect
// (strictly higher buffered class wins, otherwise live) and empties itself.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   stall               : fetch stalled this cycle
//   live_cls, live_tgt  : current highest-priority request and its target
//   pend_vld            : buffer holds a redirect
//   sel_vld, sel_tgt    : unstalled cycle has a redirect to apply, and where
module mod_pc_redirect_hold
  import pc_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  redir_cls_e        live_cls,
  input  logic [ADDR_W-1:0] live_tgt,
  output logic              pend_vld,
  output logic              sel_vld,
  output logic [ADDR_W-1:0] sel_tgt
);

  logic              pend_vld_q, pend_vld_d;
  redir_cls_e        pend_cls_q, pend_cls_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic              live_req;

  assign live_req = (live_cls != CLS_SEQ);

  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_cls_d = pend_cls_q;
    pend_tgt_d = pend_tgt_q;
    sel_vld    = 1'b0;
    sel_tgt    = live_tgt;
    if (stall) begin
      if (live_req && (!pend_vld_q || (live_cls >= pend_cls_q))) begin
        pend_vld_d = 1'b1;
        pend_cls_d = live_cls;
        pend_tgt_d = live_tgt;
      end
    end else begin
      pend_vld_d = 1'b0;
      pend_cls_d = CLS_SEQ;
      if (pend_vld_q && (pend_cls_q > live_cls)) begin
        sel_vld = 1'b1;
        sel_tgt = pend_tgt_q;
      end else if (live_req) begin
        sel_vld = 1'b1;
        sel_tgt = live_tgt;
      end
    end
  end

  // Stage p0: pending control state
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_vld_q <= 1'b0;
      pend_cls_q <= CLS_SEQ;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_cls_q <= pend_cls_d;
    end
  end

  // Target is only meaningful while pend_vld_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    pend_tgt_q <= pend_tgt_d;
  end

  assign pend_vld = pend_vld_q;

endmodule

// File: rtl/mod_pc_next_unit.sv
// Next-PC unit for the fetch stage.
// Holds the program counter, picks the next fetch address from exception,
// branch, jump or sequential sources, and defers redirects seen during a
// stall through mod_pc_redirect_hold until the stall releases.
// Ports:
//   clk, reset : clock, synchronous active-high reset (overrides everything)
//   bus        : slave side of mod_pc_next_unit_if (requests in, PC out)
module mod_pc_next_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W       = DEF_ADDR_W,
  parameter int unsigned       INC          = DEF_INC,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR),
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(DEF_EXC_VECTOR)
) (
  input logic               clk,
  input logic               reset,
  mod_pc_next_unit_if.slave bus
);

  // Sequential step wraps modulo 2^ADDR_W with no carry-out.
  function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(INC);
  endfunction

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pc_valid_q, pc_valid_d;
  redir_cls_e        live_cls;
  logic [ADDR_W-1:0] live_tgt;
  logic              pend_vld;
  logic              sel_vld;
  logic [ADDR_W-1:0] sel_tgt;

  always_comb begin
    live_cls = live_class(bus.exc_valid, bus.branch_taken, bus.jump_valid);
    live_tgt = '0;
    case (live_cls)
      CLS_EXC:    live_tgt = EXC_VECTOR;
      CLS_BRANCH: live_tgt = bus.branch_address;
      CLS_JUMP:   live_tgt = bus.jump_address;
      default:    live_tgt = '0;
    endcase
  end

  mod_pc_redirect_hold #(
    .ADDR_W (ADDR_W)
  ) u_hold (
    .clk      (clk),
    .reset    (reset),
    .stall    (bus.stall_in),
    .live_cls (live_cls),
    .live_tgt (live_tgt),
    .pend_vld (pend_vld),
    .sel_vld  (sel_vld),
    .sel_tgt  (sel_tgt)
  );

  always_comb begin
    pc_d       = pc_q;
    pc_valid_d = 1'b1;
    if (!bus.stall_in) begin
      if (sel_vld) pc_d = sel_tgt;
      else         pc_d = wrap_add(pc_q);
    end
  end

  // Stage p0: program counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
    end
  end

  assign bus.pc_out           = pc_q;
  assign bus.pc_plus_inc      = wrap_add(pc_q);
  assign bus.pc_valid         = pc_valid_q;
  assign bus.redirect_pending = pend_vld;

endmodule

// File: tb/tb_mod_pc_next_unit.sv
// Directed bench for mod_pc_next_unit: reset, sequential advance, priority,
// stall buffering, release arbitration, wrap-around and reset under stall.
module tb_mod_pc_next_unit;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  mod_pc_next_unit_if #(.ADDR_W(32)) bus ();

  mod_pc_next_unit #(
    .ADDR_W       (32),
    .INC          (4),
    .RESET_VECTOR (32'h0000_0000),
    .EXC_VECTOR   (32'h0000_0080)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr_req();
    bus.exc_valid      = 1'b0;
    bus.branch_taken   = 1'b0;
    bus.jump_valid     = 1'b0;
    bus.branch_address = 32'h0;
    bus.jump_address   = 32'h0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset        = 1'b1;
    bus.stall_in = 1'b0;
    clr_req();

    // Reset state
    tick();
    chk("rst_pc",    bus.pc_out, 32'h0);
    chk("rst_vld",   {31'b0, bus.pc_valid}, 32'h0);
    chk("rst_pend",  {31'b0, bus.redirect_pending}, 32'h0);
    chk("rst_plus",  bus.pc_plus_inc, 32'h4);

    // Sequential advance
    reset = 1'b0;
    tick(); chk("seq_pc1", bus.pc_out, 32'h4);
    chk("seq_vld", {31'b0, bus.pc_valid}, 32'h1);
    tick(); chk("seq_pc2", bus.pc_out, 32'h8);
    tick(); chk("seq_pc3", bus.pc_out, 32'hC);
    tick(); chk("seq_pc4", bus.pc_out, 32'h10);
    chk("seq_plus", bus.pc_plus_inc, 32'h14);

    // Branch beats jump in the same cycle
    bus.branch_taken = 1'b1; bus.branch_address = 32'h100;
    bus.jump_valid   = 1'b1; bus.jump_address   = 32'h200;
    tick(); chk("br_over_jmp", bus.pc_out, 32'h100);
    clr_req();
    tick(); chk("after_br", bus.pc_out, 32'h104);

    // Stall: jump, branch (higher, captured), jump (lower, ignored)
    bus.stall_in = 1'b1;
    tick(); chk("stall_hold", bus.pc_out, 32'h104);
    chk("stall_nopend", {31'b0, bus.redirect_pending}, 32'h0);
    bus.jump_valid = 1'b1; bus.jump_address = 32'h200;
    tick(); chk("pend_c3", {31'b0, bus.redirect_pending}, 32'h1);
    clr_req();
    bus.branch_taken = 1'b1; bus.branch_address = 32'h300;
    tick(); chk("pend_c4", {31'b0, bus.redirect_pending}, 32'h1);
    clr_req();
    bus.jump_valid = 1'b1; bus.jump_address = 32'h400;
    tick(); chk("pend_c5", {31'b0, bus.redirect_pending}, 32'h1);
    clr_req();
    tick(); chk("pend_c6", {31'b0, bus.redirect_pending}, 32'h1);
    chk("stall_pc", bus.pc_out, 32'h104);
    bus.stall_in = 1'b0;
    tick(); chk("rel_pc", bus.pc_out, 32'h300);
    chk("rel_pend", {31'b0, bus.redirect_pending}, 32'h0);
    tick(); chk("rel_next", bus.pc_out, 32'h304);

    // Pending branch loses to live exception on release
    bus.stall_in = 1'b1;
    bus.branch_taken = 1'b1; bus.branch_address = 32'h300;
    tick(); chk("exc_pend", {31'b0, bus.redirect_pending}, 32'h1);
    clr_req();
    bus.stall_in = 1'b0; bus.exc_valid = 1'b1;
    tick(); chk("exc_pc", bus.pc_out, 32'h80);
    chk("exc_clr", {31'b0, bus.redirect_pending}, 32'h0);
    clr_req();
    tick(); chk("exc_next", bus.pc_out, 32'h84);

    // Equal class on release: live jump wins over pending jump
    bus.stall_in = 1'b1;
    bus.jump_valid = 1'b1; bus.jump_address = 32'h600;
    tick();
    bus.stall_in = 1'b0; bus.jump_address = 32'h700;
    tick(); chk("eq_live", bus.pc_out, 32'h700);
    clr_req();

    // Higher pending class beats live jump on release
    bus.stall_in = 1'b1;
    bus.branch_taken = 1'b1; bus.branch_address = 32'h900;
    tick();
    clr_req();
    bus.stall_in = 1'b0;
    bus.jump_valid = 1'b1; bus.jump_address = 32'hA00;
    tick(); chk("pend_wins", bus.pc_out, 32'h900);
    clr_req();

    // Equal class during stall: newest target kept
    bus.stall_in = 1'b1;
    bus.branch_taken = 1'b1; bus.branch_address = 32'hB00;
    tick();
    bus.branch_address = 32'hC00;
    tick();
    clr_req();
    bus.stall_in = 1'b0;
    tick(); chk("eq_newest", bus.pc_out, 32'hC00);

    // Wrap-around
    bus.jump_valid = 1'b1; bus.jump_address = 32'hFFFF_FFFC;
    tick(); chk("wrap_pc", bus.pc_out, 32'hFFFF_FFFC);
    chk("wrap_plus", bus.pc_plus_inc, 32'h0);
    clr_req();
    tick(); chk("wrap_adv", bus.pc_out, 32'h0);

    // Reset under stall with a pending redirect
    bus.stall_in = 1'b1;
    bus.branch_taken = 1'b1; bus.branch_address = 32'h300;
    tick(); chk("rs_pend", {31'b0, bus.redirect_pending}, 32'h1);
    reset = 1'b1;
    tick(); chk("rs_pc", bus.pc_out, 32'h0);
    chk("rs_clr", {31'b0, bus.redirect_pending}, 32'h0);
    chk("rs_vld", {31'b0, bus.pc_valid}, 32'h0);
    clr_req();
    reset = 1'b0; bus.stall_in = 1'b0;
    tick(); chk("rs_after", bus.pc_out, 32'h4);
    chk("rs_vld1", {31'b0, bus.pc_valid}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
